pwm_duty_ctrl: RTL
==================

PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

Interface
REQ-001 Parameter: CBITS, 10, width of the PWM counter compare value (fixed layout below assumes 10).
REQ-002 Parameter: DEB_CYCLES, 16, number of consecutive stable cycles required to accept a switch change (range 2..255).
REQ-003 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: sw  input  4  raw asynchronous switches; sw[3:1] = target duty code, sw[0] = ramp enable.
REQ-006 Port: period_tick  input  1  one-cycle pulse marking the PWM counter wrap; the only instant duty may change.
REQ-007 Port: duty_code  output  3  registered applied duty code, 0..7.
REQ-008 Port: pulse_wide  output  CBITS  compare value {1'b0, duty_code, 1'b1, 5'd0}, i.e. duty_code*64+32.
REQ-009 Port: at_target  output  1  high when duty_code equals the debounced target.
REQ-010 Port: step_strobe  output  1  one-cycle pulse in the cycle after duty_code changes.

Function
REQ-011 Each sw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Debounce: db_sw (4 bits) SHALL update as a whole vector; a mismatch counter increments each cycle the synchronized vector differs from db_sw and clears when it matches.
REQ-013 db_sw SHALL load the synchronized vector on the cycle the mismatch counter equals DEB_CYCLES-1 with mismatch still present, then clear the counter; net latency: a change settled before edge 1 appears on db_sw at edge DEB_CYCLES+2.
REQ-014 A mismatch lasting fewer than DEB_CYCLES cycles SHALL leave db_sw unchanged.
REQ-015 Target = db_sw[3:1]; ramp_en = db_sw[0].
REQ-016 FSM states IDLE, UP, DOWN, registered every cycle: IDLE if duty_code==target, UP if duty_code<target, DOWN if duty_code>target (evaluated on post-update values).
REQ-017 duty_code SHALL change only in a cycle with period_tick=1 and rst=0.
REQ-018 On period_tick with ramp_en=1: UP -> duty_code+1, DOWN -> duty_code-1, IDLE -> hold; exactly one step per tick, never overshooting target.
REQ-019 On period_tick with ramp_en=0: duty_code SHALL load target directly.
REQ-020 period_tick in the same cycle as a db_sw update SHALL act on the pre-update db_sw value.
REQ-021 A target change mid-ramp SHALL re-evaluate direction; the ramp reverses from the current duty_code without jumping.
REQ-022 duty_code arithmetic SHALL never wrap; it stays within 0..7.
REQ-023 at_target SHALL equal (state==IDLE).
REQ-024 step_strobe SHALL be 1 for exactly one cycle following each cycle in which duty_code changed value; a direct load to an equal value produces no strobe.
REQ-025 pulse_wide SHALL be combinational from registered duty_code, glitch-free across PWM periods because duty_code changes only at period_tick.

Reset
REQ-026 While rst=1: synchronizer flops, db_sw, mismatch counter, duty_code SHALL be 0; state IDLE; step_strobe 0; period_tick ignored.
REQ-027 Post-reset outputs: duty_code=0, pulse_wide=32, at_target=1, step_strobe=0, valid in the cycle after rst is sampled high.
REQ-028 Reset asserted mid-ramp SHALL abort the ramp; no step occurs in the reset cycle.

Verification (DEB_CYCLES=4, period_tick every 16 cycles unless stated)
REQ-029 Reset: rst=1 two cycles with sw=4'b1111 -> duty_code=0, pulse_wide=32, at_target=1, step_strobe=0.
REQ-030 Glitch: sw 0000 -> 0100 for 3 cycles -> 0000 -> db_sw stays 0, duty_code stays 0, no step_strobe.
REQ-031 Ramp up: sw=4'b1111 held -> db_sw updates at edge 6; next seven ticks give duty_code 1..7, pulse_wide 96,160,...,480; seven step_strobes; at_target=1 after the 7th.
REQ-032 Direct load: from 0, sw=4'b1010 -> first tick after debounce gives duty_code=5, pulse_wide=352, one step_strobe, at_target=1.
REQ-033 Reversal: ramping up, at duty_code=3 change sw to 4'b0011 -> after debounce, ticks give 2 then 1, then hold at 1 with at_target=1.
REQ-034 Reset mid-ramp: rst=1 in a tick cycle at duty_code=4 -> duty_code=0 next cycle, no step_strobe from that tick.

Source files
------------

// File: rtl/pwm_duty_ctrl.sv
// rtl/pwm_duty_ctrl.sv - PWM duty-code controller with debounced switches and stepped ramp
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   sw[3:0]      raw async switches: sw[3:1] target duty code, sw[0] ramp enable
//   period_tick  one-cycle pulse at PWM counter wrap; the only point duty may change
//   duty_code    registered applied duty code 0..7
//   pulse_wide   compare value duty_code*64+32
//   at_target    high when duty_code equals the debounced target
//   step_strobe  one-cycle pulse in the cycle after duty_code changes

module pwm_duty_ctrl #(
   parameter int CBITS      = 10,
   parameter int DEB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       sw,
   input  logic             period_tick,
   output logic [2:0]       duty_code,
   output logic [CBITS-1:0] pulse_wide,
   output logic             at_target,
   output logic             step_strobe
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_UP   = 2'd1;
   localparam logic [1:0] ST_DOWN = 2'd2;

   localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

   logic [3:0] sw_s1, sw_s2;
   logic [3:0] db_sw, db_nxt;
   logic [7:0] mis_cnt, cnt_nxt;
   logic [2:0] duty_nxt;
   logic [1:0] state, state_nxt;

   logic [2:0] target;
   logic       ramp_en;

   assign target  = db_sw[3:1];
   assign ramp_en = db_sw[0];

   // Debounce: the whole vector is accepted only after DEB_CYCLES
   // consecutive cycles of disagreement; any agreement restarts the count.
   always_comb begin
      db_nxt  = db_sw;
      cnt_nxt = '0;
      if (sw_s2 != db_sw) begin
         if (mis_cnt == DEB_LAST) begin
            db_nxt  = sw_s2;
            cnt_nxt = '0;
         end else begin
            cnt_nxt = mis_cnt + 8'd1;
         end
      end
   end

   // Duty update acts on the pre-update db_sw. The saturation guards are
   // redundant with the state compare but keep the code from ever wrapping.
   always_comb begin
      duty_nxt = duty_code;
      if (period_tick) begin
         if (!ramp_en) begin
            duty_nxt = target;
         end else if (state == ST_UP && duty_code != 3'd7) begin
            duty_nxt = duty_code + 3'd1;
         end else if (state == ST_DOWN && duty_code != 3'd0) begin
            duty_nxt = duty_code - 3'd1;
         end
      end
   end

   // Direction is computed from the values that will be registered this
   // edge, so state always describes the visible duty_code vs db_sw pair.
   always_comb begin
      if (duty_nxt == db_nxt[3:1]) begin
         state_nxt = ST_IDLE;
      end else if (duty_nxt < db_nxt[3:1]) begin
         state_nxt = ST_UP;
      end else begin
         state_nxt = ST_DOWN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_s1       <= '0;
         sw_s2       <= '0;
         db_sw       <= '0;
         mis_cnt     <= '0;
         duty_code   <= '0;
         state       <= ST_IDLE;
         step_strobe <= 1'b0;
      end else begin
         sw_s1       <= sw;
         sw_s2       <= sw_s1;
         db_sw       <= db_nxt;
         mis_cnt     <= cnt_nxt;
         duty_code   <= duty_nxt;
         state       <= state_nxt;
         step_strobe <= (duty_nxt != duty_code);
      end
   end

   assign at_target  = (state == ST_IDLE);
   assign pulse_wide = CBITS'({duty_code, 6'b100000});

endmodule
